// File: rtl/v_div.sv
// Vector integer divide/remainder: packed SEW elements run serially
// through one radix-2 restoring divider, start/busy/done handshake.
module v_div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_A,
  input  logic [DATA_W-1:0] op_B,
  input  logic [1:0]        sew,
  input  logic [5:0]        op_instr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE
  } state_t;

  state_t state, state_n;

  logic [31:0] a_r, b_r;
  logic [1:0]  sew_r;
  logic        sgn_r, rem_op_r, bad_r;
  logic [1:0]  idx_r;
  logic [4:0]  cnt_r;
  logic [31:0] q_r, r_r, d_r, a_e_r;
  logic        neg_q_r, neg_r_r, dz_r, ovf_r;

  logic [31:0] mask, hi;
  logic [4:0]  sh, cnt_last;
  logic        last;
  logic [31:0] a_e, b_e, a_abs, b_abs;
  logic        sa, sb, dz, ovf;
  logic [32:0] tmp;
  logic        ge;
  logic [31:0] qv, rv, val;
  logic        accept;

  assign accept = (state == S_IDLE) && start;

  always_comb begin
    mask     = 32'hFFFF_FFFF;
    sh       = 5'd0;
    cnt_last = 5'd31;
    last     = 1'b1;
    unique case (sew_r)
      2'b00: begin
        mask     = 32'h0000_00FF;
        sh       = {idx_r, 3'b000};
        cnt_last = 5'd7;
        last     = (idx_r == 2'd3);
      end
      2'b01: begin
        mask     = 32'h0000_FFFF;
        sh       = {idx_r[0], 4'b0000};
        cnt_last = 5'd15;
        last     = (idx_r == 2'd1);
      end
      default: ;
    endcase
  end

  // hi is the element sign bit
  assign hi    = mask ^ (mask >> 1);
  assign a_e   = (a_r >> sh) & mask;
  assign b_e   = (b_r >> sh) & mask;
  assign sa    = sgn_r & |(a_e & hi);
  assign sb    = sgn_r & |(b_e & hi);
  assign a_abs = sa ? ((~a_e + 32'd1) & mask) : a_e;
  assign b_abs = sb ? ((~b_e + 32'd1) & mask) : b_e;
  assign dz    = (b_e == 32'd0);
  assign ovf   = sgn_r && (a_e == hi) && (b_e == mask);

  assign tmp = {r_r, |(q_r & hi)};
  assign ge  = (tmp >= {1'b0, d_r});

  always_comb begin
    qv = neg_q_r ? (~q_r + 32'd1) : q_r;
    rv = neg_r_r ? (~r_r + 32'd1) : r_r;
    if (dz_r) begin
      qv = mask;
      rv = a_e_r;
    end else if (ovf_r) begin
      qv = a_e_r;
      rv = 32'd0;
    end
    val = (rem_op_r ? rv : qv) & mask;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD: state_n = bad_r ? S_DONE : S_ITER;
      S_ITER: if (cnt_r == cnt_last) state_n = S_FIX;
      S_FIX:  state_n = last ? S_DONE : S_LOAD;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == S_LOAD),
      (state == S_ITER),
      (state == S_FIX):  busy = 1'b1;
      (state == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a_r      <= '0;
      b_r      <= '0;
      sew_r    <= '0;
      sgn_r    <= 1'b0;
      rem_op_r <= 1'b0;
      bad_r    <= 1'b0;
      idx_r    <= '0;
      cnt_r    <= '0;
      q_r      <= '0;
      r_r      <= '0;
      d_r      <= '0;
      a_e_r    <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
      result   <= '0;
    end else begin
      if (accept) begin
        a_r      <= op_A;
        b_r      <= op_B;
        sew_r    <= sew;
        sgn_r    <= op_instr[0];
        rem_op_r <= op_instr[1];
        bad_r    <= (sew == 2'b11) ||
                    (op_instr[5:2] != 4'b1000);
        idx_r    <= '0;
      end
      unique case (state)
        S_LOAD: begin
          if (bad_r) result <= '0;
          q_r     <= a_abs;
          d_r     <= b_abs;
          r_r     <= '0;
          a_e_r   <= a_e;
          neg_q_r <= sa ^ sb;
          neg_r_r <= sa;
          dz_r    <= dz;
          ovf_r   <= ovf;
          cnt_r   <= '0;
        end
        S_ITER: begin
          r_r   <= ge ? (tmp[31:0] - d_r) : tmp[31:0];
          q_r   <= {q_r[30:0], ge};
          cnt_r <= cnt_r + 5'd1;
        end
        S_FIX: begin
          result <= (result & ~(mask << sh)) | (val << sh);
          idx_r  <= idx_r + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/v_div.md
Name: v_div

Overview:
- Vector integer divide/remainder unit for the vector coprocessor execute stage; the inverse operation of the packed SIMD multiplier.
- Takes one 32-bit packed source pair per operation, elements of width SEW (8/16/32).
- Processes the elements serially through a single iterative radix-2 restoring divider and returns a packed 32-bit result.
- Uses a start/busy/done handshake; latency is fixed for each SEW.

Parameters:
- DATA_W, 32, packed operand width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  request. Accepted only in IDLE.
- op_A  in  32  packed dividend (vs2).
- op_B  in  32  packed divisor (vs1).
- sew  in  2  element width: 00=8, 01=16, 10=32, 11=reserved.
- op_instr  in  6  funct6: 100000 vdivu, 100001 vdiv, 100010 vremu, 100011 vrem.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  32  packed quotient or remainder. Held until the next accept.

Behaviour:
- Reset (async, nrst=0): state=IDLE; busy=0, done=0, result=0; all internal registers cleared. Reset mid-operation aborts it and no done is produced.
- Accept: start=1 in IDLE (cycle 0). op_A, op_B, sew and op_instr are latched. Inputs are ignored after cycle 0.
- start while busy or done=1 is ignored (not queued).
- Elements: E = 32/W, where W = 8, 16 or 32. Element i occupies bits [W*i+W-1 : W*i] and is processed i=0 first.
- States:
  - IDLE -> LOAD on accept.
  - LOAD (1 cycle): select element i; form absolute values when signed; record sign flags and special-case flags.
  - ITER (W cycles): one shift/subtract per cycle on a W-bit partial remainder, producing one quotient bit.
  - FIX (1 cycle): apply sign correction and special-case override; write element i into the result register.
  - After FIX: LOAD if i < E-1, otherwise DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Latency: done is asserted in cycle E*(W+2)+1, i.e. 41 for SEW8, 37 for SEW16, 35 for SEW32.
- Special cases do not shorten latency.
- Signed results:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones (W bits); remainder = dividend. Applies to both signed and unsigned.
- Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
- Reserved sew=11 or an unsupported op_instr: no iterations. result=0 and done asserted in cycle 2 (IDLE->DONE via one busy cycle).
- The result register updates only in FIX (or to 0 in the reserved case). Between operations the last result stays stable.
- Back-to-back: start may be high in the cycle after done. It is accepted because the state is IDLE.

Test Plan:
- SEW8 vdiv, op_A=0x80F96407, op_B=0xFF020700 -> result=0x80FD0EFF (overflow, -7/2=-3, 100/7=14, 7/0=0xFF); done in cycle 41 only; busy high in cycles 1-40.
- SEW8 vrem, same operands -> result=0x00FF0207; done cycle 41.
- SEW16 vdivu, op_A=0xFFFF0064, op_B=0x00100000 -> result=0x0FFFFFFF; done cycle 37.
- SEW32 vrem, op_A=0xFFFFFFF9, op_B=0x00000003 -> result=0xFFFFFFFF. Same operands with vdiv -> 0xFFFFFFFE. Both done in cycle 35.
- start pulsed at cycle 10 of a SEW32 op with different operands -> ignored; first result unchanged, single done.
- nrst low at cycle 20 of a SEW8 op -> busy, done and result go to 0 immediately; no done follows. A new accept after release completes normally. sew=11 -> result=0, done in cycle 2.
